alu_cmd_issuer: RTL and testbench
=================================

ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 1 (legal 1..15), number of cycles operands are held on the ALU port before sampling.
REQ-003 SHALL have one clock; reset is synchronous and active-low.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 cmd_valid  in  1  command request.
REQ-007 cmd_ready  out  1  command accepted when valid&ready high on a clk edge.
REQ-008 cmd_sel  in  4  ALU opcode.
REQ-009 cmd_a, cmd_b  in  WIDTH each  operands.
REQ-010 cmd_cin  in  1  carry-in.
REQ-011 cmd_use_acc  in  1  substitute accumulator for cmd_a.
REQ-012 alu_a, alu_b  out  WIDTH each; alu_sel out 4; alu_cin out 1  drive external ALU.
REQ-013 alu_y  in  WIDTH; alu_cout, alu_neg, alu_zero, alu_ovf  in  1 each  ALU results.
REQ-014 rsp_valid  out  1; rsp_ready  in  1  response handshake.
REQ-015 rsp_y  out  WIDTH; rsp_flags  out  4  {cout,neg,zero,ovf}.
REQ-016 acc  out  WIDTH  accumulator (last captured result).
REQ-017 busy  out  1  high in any state except IDLE.

Function
REQ-018 FSM states SHALL be IDLE, DRIVE, RESP.
REQ-019 cmd_ready SHALL equal 1 only in IDLE; no command is buffered.
REQ-020 IDLE -> DRIVE on accept; alu_a := cmd_use_acc ? acc : cmd_a, alu_b/alu_sel/alu_cin := cmd fields, settle counter := SETTLE_CYCLES-1.
REQ-021 In DRIVE, alu_* outputs SHALL be stable; counter decrements each cycle; at counter==0 the block SHALL capture alu_y and flags into rsp_y/rsp_flags and acc, and go to RESP.
REQ-022 Latency: accept at edge T -> rsp_valid high after edge T+SETTLE_CYCLES.
REQ-023 In RESP rsp_valid=1, rsp_y/rsp_flags stable until rsp_ready sampled high; then -> IDLE, rsp_valid=0 next cycle.
REQ-024 rsp_ready held high continuously SHALL give throughput of one command per SETTLE_CYCLES+2 cycles.
REQ-025 Outside DRIVE, alu_* outputs SHALL hold last driven values.
REQ-026 cmd_valid while busy SHALL be ignored (not accepted, no state change).
REQ-027 cmd_sel values outside the package opcode list SHALL still be issued and captured unchanged; no error flag.
REQ-028 acc SHALL change only on capture (REQ-021); WIDTH-bit, no saturation.

Reset
REQ-029 rst_n low at an edge SHALL force IDLE, counter 0, acc 0, rsp_y 0, rsp_flags 0, alu_a/alu_b 0, alu_sel 0, alu_cin 0, rsp_valid 0, busy 0, cmd_ready 1 the following cycle.
REQ-030 Reset mid-DRIVE or mid-RESP SHALL discard the command; no response issued.

Structure
REQ-031 Shared package alu_pkg SHALL hold opcode constants (0000 AND, 0001 OR, 0010 NOT, 0011 NOR, 0100 XOR, 0101 NAND, 0110 ADD, 0111 SUB), the flag bit indices, and the FSM state enum.
REQ-032 One sub-module alu_settle_cnt (4-bit load/decrement counter with zero flag) SHALL implement the settle timer.

Verification (bench instantiates the team ALU as the responder)
REQ-033 ADD a=5,b=7,cin=0, SETTLE=1, rsp_ready=1 -> rsp_valid one cycle after DRIVE, rsp_y=12, flags=0000.
REQ-034 SUB a=3,b=3 -> rsp_y=0, zero=1, cout=1; then cmd_use_acc=1 ADD b=9 -> rsp_y=9.
REQ-035 ADD a=0x7FFFFFFF,b=1 -> rsp_y=0x80000000, neg=1, ovf=1.
REQ-036 rsp_ready low 5 cycles in RESP -> rsp_valid/rsp_y stable, cmd_ready=0, second cmd_valid ignored.
REQ-037 SETTLE_CYCLES=4 -> alu_* stable 4 cycles, rsp_valid at accept+4.
REQ-038 rst_n low during DRIVE -> next cycle IDLE, acc=0, no rsp_valid pulse.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Package     : alu_pkg
// Description : Shared ALU opcodes, result-flag bit positions and the command
//               issuer FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // ALU opcodes understood by the team ALU
    localparam logic [3:0] c_OP_AND  = 4'b0000;
    localparam logic [3:0] c_OP_OR   = 4'b0001;
    localparam logic [3:0] c_OP_NOT  = 4'b0010;
    localparam logic [3:0] c_OP_NOR  = 4'b0011;
    localparam logic [3:0] c_OP_XOR  = 4'b0100;
    localparam logic [3:0] c_OP_NAND = 4'b0101;
    localparam logic [3:0] c_OP_ADD  = 4'b0110;
    localparam logic [3:0] c_OP_SUB  = 4'b0111;

    // Bit positions inside the 4-bit flag word {cout, neg, zero, ovf}
    localparam int c_FLAG_COUT = 3;
    localparam int c_FLAG_NEG  = 2;
    localparam int c_FLAG_ZERO = 1;
    localparam int c_FLAG_OVF  = 0;

    // Command issuer FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } alu_state_t;

    // Assemble the flag word from the individual ALU flag outputs
    function automatic logic [3:0] pack_flags(input logic cout, input logic neg,
                                              input logic zero, input logic ovf);
        logic [3:0] f;
        f              = 4'b0000;
        f[c_FLAG_COUT] = cout;
        f[c_FLAG_NEG]  = neg;
        f[c_FLAG_ZERO] = zero;
        f[c_FLAG_OVF]  = ovf;
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_cmd_issuer_if.sv
`default_nettype none
// ============================================================================
// Interface   : alu_cmd_issuer_if
// Description : Command, ALU-drive and response signals of the command issuer.
//               master = the issuer, slave = the command source / ALU / sink.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_cmd_issuer_if #(
    parameter int WIDTH = 32
);
    // Command channel
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_sel;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             cmd_cin;
    logic             cmd_use_acc;

    // External ALU port
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_sel;
    logic             alu_cin;
    logic [WIDTH-1:0] alu_y;
    logic             alu_cout;
    logic             alu_neg;
    logic             alu_zero;
    logic             alu_ovf;

    // Response channel and status
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_y;
    logic [3:0]       rsp_flags;
    logic [WIDTH-1:0] acc;
    logic             busy;

    modport master (
        input  cmd_valid, cmd_sel, cmd_a, cmd_b, cmd_cin, cmd_use_acc,
        output cmd_ready,
        output alu_a, alu_b, alu_sel, alu_cin,
        input  alu_y, alu_cout, alu_neg, alu_zero, alu_ovf,
        output rsp_valid, rsp_y, rsp_flags, acc, busy,
        input  rsp_ready
    );

    modport slave (
        output cmd_valid, cmd_sel, cmd_a, cmd_b, cmd_cin, cmd_use_acc,
        input  cmd_ready,
        input  alu_a, alu_b, alu_sel, alu_cin,
        output alu_y, alu_cout, alu_neg, alu_zero, alu_ovf,
        input  rsp_valid, rsp_y, rsp_flags, acc, busy,
        output rsp_ready
    );
endinterface
`default_nettype wire

// File: rtl/alu_settle_cnt.sv
`default_nettype none
// ============================================================================
// Module      : alu_settle_cnt
// Description : 4-bit load/decrement counter with zero flag; times how long
//               operands sit on the ALU port before the result is sampled.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_settle_cnt (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       i_load,
    input  wire logic [3:0] i_load_val,
    input  wire logic       i_dec,
    output logic            o_zero
);

    logic [3:0] r_cnt;

    // Load has priority; decrement stops at zero so the counter never wraps
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= 4'd0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign o_zero = (r_cnt == 4'd0);

endmodule
`default_nettype wire

// File: rtl/alu_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_issuer
// Description : Accepts one ALU command at a time, holds the operands on an
//               external ALU for SETTLE_CYCLES cycles, captures the result
//               and flags, and presents them on a valid/ready response port.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 1
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    alu_cmd_issuer_if.master   bus
);

    localparam logic [3:0] c_SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    generate
        if ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES > 15)) begin : g_bad_settle
            $error("alu_cmd_issuer: SETTLE_CYCLES must be within 1..15");
        end
    endgenerate

    alu_state_t       r_state;
    logic             r_cmd_ready;
    logic             r_busy;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [3:0]       r_alu_sel;
    logic             r_alu_cin;
    logic [WIDTH-1:0] r_rsp_y;
    logic [3:0]       r_rsp_flags;
    logic [WIDTH-1:0] r_acc;

    logic             w_accept;
    logic             w_cnt_dec;
    logic             w_cnt_zero;

    // Ready is only ever asserted in IDLE, so valid alone completes the handshake there
    assign w_accept  = (r_state == ST_IDLE) && bus.cmd_valid;
    assign w_cnt_dec = (r_state == ST_DRIVE) && !w_cnt_zero;

    alu_settle_cnt u_settle_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_accept),
        .i_load_val (c_SETTLE_LOAD),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    // Issue FSM: latch command onto the ALU, wait for settle, capture, hand off response
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_sel   <= 4'd0;
            r_alu_cin   <= 1'b0;
            r_rsp_y     <= '0;
            r_rsp_flags <= 4'd0;
            r_acc       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        // Opcode is forwarded as-is, including codes the ALU does not define
                        r_alu_a     <= bus.cmd_use_acc ? r_acc : bus.cmd_a;
                        r_alu_b     <= bus.cmd_b;
                        r_alu_sel   <= bus.cmd_sel;
                        r_alu_cin   <= bus.cmd_cin;
                        r_state     <= ST_DRIVE;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (w_cnt_zero) begin
                        r_rsp_y     <= bus.alu_y;
                        r_rsp_flags <= pack_flags(bus.alu_cout, bus.alu_neg,
                                                  bus.alu_zero, bus.alu_ovf);
                        r_acc       <= bus.alu_y;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.busy      = r_busy;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_y     = r_rsp_y;
    assign bus.rsp_flags = r_rsp_flags;
    assign bus.acc       = r_acc;
    assign bus.alu_a     = r_alu_a;
    assign bus.alu_b     = r_alu_b;
    assign bus.alu_sel   = r_alu_sel;
    assign bus.alu_cin   = r_alu_cin;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_cmd_issuer
// Description : Testbench for alu_cmd_issuer with a behavioural team ALU as the
//               responder; one instance with SETTLE_CYCLES=1, one with 4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_issuer;
    import alu_pkg::*;

    logic clk;
    logic rst_n1;
    logic rst_n4;

    int n_cmp;
    int n_err;

    alu_cmd_issuer_if #(.WIDTH(32)) b1 ();
    alu_cmd_issuer_if #(.WIDTH(32)) b4 ();

    alu_cmd_issuer #(.WIDTH(32), .SETTLE_CYCLES(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n1),
        .bus   (b1)
    );

    alu_cmd_issuer #(.WIDTH(32), .SETTLE_CYCLES(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n4),
        .bus   (b4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] y;
        logic [3:0]  f;
    } alu_res_t;

    // Team ALU behaviour; undefined opcodes produce {a[27:0], sel} so pass-through is visible
    function automatic alu_res_t alu_model(input logic [3:0] sel, input logic [31:0] a,
                                           input logic [31:0] b, input logic cin);
        alu_res_t r;
        logic [32:0] s;
        logic c;
        logic v;
        c = 1'b0;
        v = 1'b0;
        s = '0;
        r.y = '0;
        case (sel)
            c_OP_AND:  r.y = a & b;
            c_OP_OR:   r.y = a | b;
            c_OP_NOT:  r.y = ~a;
            c_OP_NOR:  r.y = ~(a | b);
            c_OP_XOR:  r.y = a ^ b;
            c_OP_NAND: r.y = ~(a & b);
            c_OP_ADD: begin
                s   = {1'b0, a} + {1'b0, b} + {32'd0, cin};
                r.y = s[31:0];
                c   = s[32];
                v   = (a[31] == b[31]) && (r.y[31] != a[31]);
            end
            c_OP_SUB: begin
                s   = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r.y = s[31:0];
                c   = s[32];
                v   = (a[31] != b[31]) && (r.y[31] != a[31]);
            end
            default:   r.y = {a[27:0], sel};
        endcase
        r.f = {c, r.y[31], (r.y == 32'd0), v};
        return r;
    endfunction

    alu_res_t w_res1;
    alu_res_t w_res4;

    always_comb begin
        w_res1 = alu_model(b1.alu_sel, b1.alu_a, b1.alu_b, b1.alu_cin);
        w_res4 = alu_model(b4.alu_sel, b4.alu_a, b4.alu_b, b4.alu_cin);
    end

    assign b1.alu_y    = w_res1.y;
    assign b1.alu_cout = w_res1.f[3];
    assign b1.alu_neg  = w_res1.f[2];
    assign b1.alu_zero = w_res1.f[1];
    assign b1.alu_ovf  = w_res1.f[0];
    assign b4.alu_y    = w_res4.y;
    assign b4.alu_cout = w_res4.f[3];
    assign b4.alu_neg  = w_res4.f[2];
    assign b4.alu_zero = w_res4.f[1];
    assign b4.alu_ovf  = w_res4.f[0];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        use_acc;
        logic [31:0] exp_alu_a;
        logic [31:0] exp_y;
        logic [3:0]  exp_f;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int first_idx;
        int second_idx;
        logic seen;

        n_cmp = 0;
        n_err = 0;

        // {sel, a, b, cin, use_acc, expected alu_a, expected y, expected flags {cout,neg,zero,ovf}}
        vecs[0]  = '{c_OP_ADD,  32'd5,          32'd7,          1'b0, 1'b0, 32'd5,          32'd12,         4'b0000};
        vecs[1]  = '{c_OP_SUB,  32'd3,          32'd3,          1'b0, 1'b0, 32'd3,          32'd0,          4'b1010};
        vecs[2]  = '{c_OP_ADD,  32'd100,        32'd9,          1'b0, 1'b1, 32'd0,          32'd9,          4'b0000};
        vecs[3]  = '{c_OP_ADD,  32'h7FFF_FFFF,  32'd1,          1'b0, 1'b0, 32'h7FFF_FFFF,  32'h8000_0000,  4'b0101};
        vecs[4]  = '{c_OP_AND,  32'hF0F0_F0F0,  32'hFF00_FF00,  1'b0, 1'b0, 32'hF0F0_F0F0,  32'hF000_F000,  4'b0100};
        vecs[5]  = '{c_OP_XOR,  32'hAAAA_AAAA,  32'hAAAA_AAAA,  1'b0, 1'b0, 32'hAAAA_AAAA,  32'd0,          4'b0010};
        vecs[6]  = '{c_OP_NOT,  32'd0,          32'd0,          1'b0, 1'b0, 32'd0,          32'hFFFF_FFFF,  4'b0100};
        vecs[7]  = '{c_OP_ADD,  32'hFFFF_FFFF,  32'd0,          1'b1, 1'b0, 32'hFFFF_FFFF,  32'd0,          4'b1010};
        vecs[8]  = '{c_OP_ADD,  32'd77,         32'd5,          1'b1, 1'b1, 32'd0,          32'd6,          4'b0000};
        vecs[9]  = '{4'hF,      32'd1,          32'd2,          1'b0, 1'b0, 32'd1,          32'h0000_001F,  4'b0000};
        vecs[10] = '{c_OP_SUB,  32'h8000_0000,  32'd1,          1'b0, 1'b0, 32'h8000_0000,  32'h7FFF_FFFF,  4'b1001};
        vecs[11] = '{c_OP_OR,   32'h0000_00F0,  32'h0000_000F,  1'b0, 1'b0, 32'h0000_00F0,  32'h0000_00FF,  4'b0000};
        vecs[12] = '{c_OP_NAND, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 1'b0, 32'hFFFF_FFFF,  32'd0,          4'b0010};
        vecs[13] = '{c_OP_NOR,  32'd0,          32'd0,          1'b0, 1'b0, 32'd0,          32'hFFFF_FFFF,  4'b0100};

        rst_n1 = 1'b0;
        rst_n4 = 1'b0;
        b1.cmd_valid = 1'b0; b1.cmd_sel = 4'd0; b1.cmd_a = '0; b1.cmd_b = '0;
        b1.cmd_cin = 1'b0; b1.cmd_use_acc = 1'b0; b1.rsp_ready = 1'b1;
        b4.cmd_valid = 1'b0; b4.cmd_sel = 4'd0; b4.cmd_a = '0; b4.cmd_b = '0;
        b4.cmd_cin = 1'b0; b4.cmd_use_acc = 1'b0; b4.rsp_ready = 1'b1;

        repeat (3) @(negedge clk);

        // Reset state of both instances
        check("rst1_cmd_ready", b1.cmd_ready, 1);
        check("rst1_busy",      b1.busy,      0);
        check("rst1_rsp_valid", b1.rsp_valid, 0);
        check("rst1_acc",       b1.acc,       0);
        check("rst1_alu_a",     b1.alu_a,     0);
        check("rst1_alu_sel",   b1.alu_sel,   0);
        check("rst1_rsp_y",     b1.rsp_y,     0);
        check("rst1_rsp_flags", b1.rsp_flags, 0);
        check("rst4_cmd_ready", b4.cmd_ready, 1);
        check("rst4_busy",      b4.busy,      0);
        check("rst4_acc",       b4.acc,       0);
        rst_n1 = 1'b1;
        rst_n4 = 1'b1;

        // Table-driven commands on the SETTLE_CYCLES=1 instance, rsp_ready held high
        for (int i = 0; i < NV; i++) begin
            check($sformatf("v%0d_cmd_ready", i), b1.cmd_ready, 1);
            b1.cmd_valid   = 1'b1;
            b1.cmd_sel     = vecs[i].sel;
            b1.cmd_a       = vecs[i].a;
            b1.cmd_b       = vecs[i].b;
            b1.cmd_cin     = vecs[i].cin;
            b1.cmd_use_acc = vecs[i].use_acc;
            @(negedge clk);
            b1.cmd_valid = 1'b0;
            lat = 0;
            while ((b1.rsp_valid !== 1'b1) && (lat < 20)) begin
                @(negedge clk);
                lat++;
            end
            check($sformatf("v%0d_latency", i),   lat,          1);
            check($sformatf("v%0d_rsp_y", i),     b1.rsp_y,     vecs[i].exp_y);
            check($sformatf("v%0d_rsp_flags", i), b1.rsp_flags, vecs[i].exp_f);
            check($sformatf("v%0d_acc", i),       b1.acc,       vecs[i].exp_y);
            check($sformatf("v%0d_alu_a", i),     b1.alu_a,     vecs[i].exp_alu_a);
            check($sformatf("v%0d_alu_sel", i),   b1.alu_sel,   vecs[i].sel);
            @(negedge clk);
            check($sformatf("v%0d_rsp_drop", i),  b1.rsp_valid, 0);
        end

        // Back-pressure: response held while rsp_ready low; a new command is ignored
        b1.rsp_ready   = 1'b0;
        b1.cmd_valid   = 1'b1;
        b1.cmd_sel     = c_OP_ADD;
        b1.cmd_a       = 32'd2;
        b1.cmd_b       = 32'd3;
        b1.cmd_cin     = 1'b0;
        b1.cmd_use_acc = 1'b0;
        @(negedge clk);
        b1.cmd_valid = 1'b0;
        lat = 0;
        while ((b1.rsp_valid !== 1'b1) && (lat < 20)) begin
            @(negedge clk);
            lat++;
        end
        check("bp_latency", lat, 1);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp%0d_rsp_valid", k), b1.rsp_valid, 1);
            check($sformatf("bp%0d_rsp_y", k),     b1.rsp_y,     5);
            check($sformatf("bp%0d_cmd_ready", k), b1.cmd_ready, 0);
            check($sformatf("bp%0d_busy", k),      b1.busy,      1);
            if (k == 0) begin
                b1.cmd_valid = 1'b1;
                b1.cmd_a     = 32'd99;
                b1.cmd_b     = 32'd1;
            end
            if (k == 4) begin
                b1.cmd_valid = 1'b0;
                b1.rsp_ready = 1'b1;
            end
            @(negedge clk);
        end
        check("bp_end_rsp_valid", b1.rsp_valid, 0);
        check("bp_end_cmd_ready", b1.cmd_ready, 1);
        check("bp_end_busy",      b1.busy,      0);
        check("bp_end_alu_a",     b1.alu_a,     2);
        check("bp_end_acc",       b1.acc,       5);

        // Reset while a response is pending discards it
        b1.rsp_ready = 1'b0;
        b1.cmd_valid = 1'b1;
        b1.cmd_a     = 32'd4;
        b1.cmd_b     = 32'd4;
        @(negedge clk);
        b1.cmd_valid = 1'b0;
        lat = 0;
        while ((b1.rsp_valid !== 1'b1) && (lat < 20)) begin
            @(negedge clk);
            lat++;
        end
        check("rr_latency", lat, 1);
        rst_n1 = 1'b0;
        @(negedge clk);
        check("rr_rsp_valid", b1.rsp_valid, 0);
        check("rr_rsp_y",     b1.rsp_y,     0);
        check("rr_acc",       b1.acc,       0);
        check("rr_cmd_ready", b1.cmd_ready, 1);
        rst_n1 = 1'b1;
        b1.rsp_ready = 1'b1;

        // Throughput: cmd_valid and rsp_ready held high -> one response every 3 cycles
        b1.cmd_valid = 1'b1;
        b1.cmd_a     = 32'd1;
        b1.cmd_b     = 32'd1;
        first_idx  = -1;
        second_idx = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (b1.rsp_valid === 1'b1) begin
                if (first_idx < 0) first_idx = i;
                else if (second_idx < 0) second_idx = i;
            end
        end
        b1.cmd_valid = 1'b0;
        check("tp_first", first_idx, 1);
        check("tp_gap",   second_idx - first_idx, 3);
        repeat (4) @(negedge clk);

        // SETTLE_CYCLES=4: operands stable while driving, response at accept+4
        b4.cmd_valid = 1'b1;
        b4.cmd_sel   = c_OP_SUB;
        b4.cmd_a     = 32'd10;
        b4.cmd_b     = 32'd4;
        @(negedge clk);
        b4.cmd_valid = 1'b0;
        lat = 0;
        while ((b4.rsp_valid !== 1'b1) && (lat < 20)) begin
            check($sformatf("s4_drive%0d_alu_a", lat), b4.alu_a, 10);
            check($sformatf("s4_drive%0d_alu_b", lat), b4.alu_b, 4);
            @(negedge clk);
            lat++;
        end
        check("s4_latency",   lat,          4);
        check("s4_rsp_y",     b4.rsp_y,     6);
        check("s4_rsp_flags", b4.rsp_flags, 4'b1000);
        check("s4_acc",       b4.acc,       6);
        @(negedge clk);
        check("s4_rsp_drop",  b4.rsp_valid, 0);
        check("s4_hold_alu_a", b4.alu_a,    10);

        // Reset during DRIVE: command discarded, no response
        b4.cmd_valid = 1'b1;
        b4.cmd_sel   = c_OP_ADD;
        b4.cmd_a     = 32'd1;
        b4.cmd_b     = 32'd1;
        @(negedge clk);
        b4.cmd_valid = 1'b0;
        check("rd_busy_before", b4.busy, 1);
        rst_n4 = 1'b0;
        @(negedge clk);
        check("rd_cmd_ready", b4.cmd_ready, 1);
        check("rd_busy",      b4.busy,      0);
        check("rd_acc",       b4.acc,       0);
        check("rd_alu_a",     b4.alu_a,     0);
        rst_n4 = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (b4.rsp_valid !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        check("rd_no_rsp", seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
